// File: rtl/fastram_ctrl.sv
// 68020 FastRAM DRAM controller: RAS/CAS sequencing, byte-lane CAS, CBR refresh.
// Define FASTRAM_AUTOCONFIG_EN to take the base address from a config-space write.
module fastram_ctrl #(
  parameter int         BANKS         = 2,
  parameter logic [3:0] BASE_DEFAULT  = 4'h2,
  parameter int         REFRESH_DIV   = 210,
  parameter int         PRECHARGE_CYC = 2
) (
  input  logic             CLKCPU,
  input  logic             RESET,
  input  logic             AS20,
  input  logic             DS20,
  input  logic             RW20,
  input  logic [23:0]      A,
  input  logic [1:0]       SIZ,
  input  logic [7:0]       D,
  output logic [1:0]       DSACK,
  output logic [BANKS-1:0] RAS,
  output logic [3:0]       CAS,
  output logic             RAMOE,
  output logic             RAM_MUX
);

  localparam int         RCW  = $clog2(REFRESH_DIV + 1);
  localparam logic [4:0] SPAN = 5'(2 * BANKS);

  typedef enum logic [3:0] {
    IDLE, ROW, COL, ACK, PRE, REF_CAS, REF_RAS, REF_PRE, CFG
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       base;
  logic             configured, shutup;
  logic [3:0]       off;
  logic             hit, cfg_hit;
  logic [1:0]       hit_bank;
  logic [2:0]       lane_n, lane_last;
  logic [3:0]       wr_cas;
  logic [RCW-1:0]   ref_cnt;
  logic             tick, pending;
  logic [7:0]       cnt;
  logic [1:0]       bank;
  logic             rd;
  logic [3:0]       cas_lat;
  logic [BANKS-1:0] bank_ras;
  logic             unused_ok;

  // Bank index is the 2 MB slot relative to the configured base.
  assign off       = A[23:20] - base;
  assign hit       = !AS20 && configured && !shutup && (A[23:20] >= base) && ({1'b0, off} < SPAN);
  assign hit_bank  = off[2:1];
  assign tick      = (ref_cnt == RCW'(REFRESH_DIV - 1));
  assign unused_ok = ^{D, A[19:2]};

`ifdef FASTRAM_AUTOCONFIG_EN
  assign cfg_hit = !AS20 && !RW20 && (A[23:16] == 8'hE8) && !configured && !shutup;

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      base       <= 4'h0;
      configured <= 1'b0;
      shutup     <= 1'b0;
    end else if (state == IDLE && state_nxt == CFG) begin
      if (A[15:0] == 16'h0048) begin
        base       <= D[7:4];
        configured <= 1'b1;
      end else if (A[15:0] == 16'h004C) begin
        shutup <= 1'b1;
      end
    end
  end
`else
  assign cfg_hit    = 1'b0;
  assign base       = BASE_DEFAULT;
  assign configured = 1'b1;
  assign shutup     = 1'b0;
`endif

  // Write lanes: bytes offset..offset+size-1 clipped to the long word; byte k on CAS[3-k].
  always_comb begin
    lane_n    = (SIZ == 2'b00) ? 3'd4 : {1'b0, SIZ};
    lane_last = {1'b0, A[1:0]} + lane_n - 3'd1;
    wr_cas    = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) >= {1'b0, A[1:0]} && 3'(k) <= lane_last) wr_cas[3-k] = 1'b0;
    end
  end

  always_comb begin
    bank_ras = '1;
    for (int b = 0; b < BANKS; b++) begin
      if (bank == 2'(b)) bank_ras[b] = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pending)                state_nxt = REF_CAS;
        else if (hit)               state_nxt = ROW;
        else if (cfg_hit && !DS20)  state_nxt = CFG;
      end
      ROW:     state_nxt = COL;
      COL:     if (rd || !DS20) state_nxt = ACK;
      ACK:     if (AS20) state_nxt = PRE;
      PRE:     if (cnt == 8'd0) state_nxt = IDLE;
      REF_CAS: state_nxt = REF_RAS;
      REF_RAS: if (cnt == 8'd0) state_nxt = REF_PRE;
      REF_PRE: if (cnt == 8'd0) state_nxt = IDLE;
      CFG:     if (AS20) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state   <= IDLE;
      ref_cnt <= '0;
      pending <= 1'b0;
      cnt     <= 8'd0;
      bank    <= 2'd0;
      rd      <= 1'b1;
      cas_lat <= 4'b1111;
    end else begin
      state   <= state_nxt;
      ref_cnt <= tick ? '0 : ref_cnt + RCW'(1);
      // Clearing on refresh entry beats a coincident tick, so that tick is dropped.
      if (state == IDLE && pending) pending <= 1'b0;
      else if (tick)                pending <= 1'b1;

      if (state_nxt != state) begin
        case (state_nxt)
          PRE, REF_PRE: cnt <= 8'(PRECHARGE_CYC - 1);
          REF_RAS:      cnt <= 8'd1;
          default:      cnt <= 8'd0;
        endcase
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end

      if (state == IDLE && state_nxt == ROW) begin
        bank    <= hit_bank;
        rd      <= RW20;
        cas_lat <= RW20 ? 4'b0000 : wr_cas;
      end
    end
  end

  always_comb begin
    DSACK   = 2'b11;
    RAS     = '1;
    CAS     = 4'b1111;
    RAMOE   = 1'b1;
    RAM_MUX = 1'b0;
    case (state)
      ROW: RAS = bank_ras;
      COL: begin
        RAS     = bank_ras;
        RAM_MUX = 1'b1;
      end
      ACK: begin
        RAS     = bank_ras;
        RAM_MUX = 1'b1;
        CAS     = cas_lat;
        DSACK   = 2'b00;
        RAMOE   = !rd;
      end
      REF_CAS: CAS = 4'b0000;
      REF_RAS: begin
        CAS = 4'b0000;
        RAS = '0;
      end
      CFG:     DSACK = 2'b00;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fastram_ctrl.sv
// Bench for fastram_ctrl: directed and random 68020 cycles against an address-map model.
module tb_fastram_ctrl;

  localparam int BANKS         = 2;
  localparam int REFRESH_DIV   = 210;
  localparam int PRECHARGE_CYC = 2;

  logic             CLKCPU = 1'b0;
  logic             RESET  = 1'b1;
  logic             AS20   = 1'b1;
  logic             DS20   = 1'b1;
  logic             RW20   = 1'b1;
  logic [23:0]      A      = '0;
  logic [1:0]       SIZ    = '0;
  logic [7:0]       D      = '0;
  logic [1:0]       DSACK;
  logic [BANKS-1:0] RAS;
  logic [3:0]       CAS;
  logic             RAMOE;
  logic             RAM_MUX;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edges  = 0;
  int model_base_mb = 2;
  bit model_cfg;
  logic [BANKS-1:0] ras_idle = '1;

  fastram_ctrl #(
    .BANKS(BANKS), .BASE_DEFAULT(4'h2), .REFRESH_DIV(REFRESH_DIV), .PRECHARGE_CYC(PRECHARGE_CYC)
  ) dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20), .A(A), .SIZ(SIZ),
    .D(D), .DSACK(DSACK), .RAS(RAS), .CAS(CAS), .RAMOE(RAMOE), .RAM_MUX(RAM_MUX)
  );

  always #5 CLKCPU = ~CLKCPU;
  always @(posedge CLKCPU) n_edges <= RESET ? 0 : n_edges + 1;

  task automatic step();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [23:0] a);
    int rel;
    rel = int'(a) - model_base_mb * (1 << 20);
    return model_cfg && rel >= 0 && rel < BANKS * (1 << 21);
  endfunction

  function automatic logic [BANKS-1:0] m_ras(input logic [23:0] a);
    logic [BANKS-1:0] r;
    int rel;
    r   = '1;
    rel = int'(a) - model_base_mb * (1 << 20);
    r[rel / (1 << 21)] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] m_cas(input logic [23:0] a, input logic rw, input logic [1:0] siz);
    logic [3:0] c;
    int o, n;
    if (rw) return 4'b0000;
    c = 4'b1111;
    o = int'(a[1:0]);
    n = (siz == 2'b00) ? 4 : int'(siz);
    for (int b = 0; b < 4; b++) if (b >= o && b < o + n) c[3-b] = 1'b0;
    return c;
  endfunction

  // Start accesses only where no refresh tick can land inside them.
  task automatic wait_window(input int hi);
    for (int i = 0; i < 400; i++) begin
      if (n_edges % REFRESH_DIV >= 8 && n_edges % REFRESH_DIV <= hi) break;
      step();
    end
  endtask

  task automatic access(input logic [23:0] a, input logic rw, input logic [1:0] siz,
                        input int wdly, input int hold, input int pre_wait, input bit b2b);
    bit h;
    logic [BANKS-1:0] er;
    logic [3:0] ec;
    h  = m_hit(a);
    er = h ? m_ras(a) : ras_idle;
    ec = m_cas(a, rw, siz);
    A = a; RW20 = rw; SIZ = siz; D = 8'h00; AS20 = 1'b0; DS20 = rw ? 1'b0 : 1'b1;
    if (!h) begin
      for (int i = 0; i < 4; i++) begin
        step();
        chk("nohit_dsack", DSACK, 2'b11);
        chk("nohit_ras", RAS, ras_idle);
      end
    end else begin
      for (int i = 0; i < pre_wait; i++) begin
        step();
        chk("precharge_ras", RAS, ras_idle);
      end
      step();
      chk("row_ras", RAS, er);
      chk("row_mux", RAM_MUX, 1'b0);
      step();
      chk("col_mux", RAM_MUX, 1'b1);
      chk("col_cas", CAS, 4'b1111);
      if (!rw) begin
        for (int i = 0; i < wdly; i++) begin
          step();
          chk("col_wait_dsack", DSACK, 2'b11);
        end
        DS20 = 1'b0;
      end
      step();
      chk("ack_dsack", DSACK, 2'b00);
      chk("ack_cas", CAS, ec);
      chk("ack_oe", RAMOE, rw ? 1'b0 : 1'b1);
      chk("ack_ras", RAS, er);
      for (int i = 0; i < hold; i++) begin
        step();
        chk("ack_hold", DSACK, 2'b00);
      end
    end
    AS20 = 1'b1; DS20 = 1'b1;
    step();
    chk("rel_ras", RAS, ras_idle);
    chk("rel_dsack", DSACK, 2'b11);
    chk("rel_cas", CAS, 4'b1111);
    chk("rel_oe", RAMOE, 1'b1);
    if (h && !b2b) begin
      step();
      step();
    end
  endtask

  task automatic cfg_write(input logic [23:0] a, input logic [7:0] d, input bit ack);
    wait_window(180);
    A = a; D = d; RW20 = 1'b0; SIZ = 2'b01; AS20 = 1'b0; DS20 = 1'b0;
    step();
    chk("cfg_dsack", DSACK, ack ? 2'b00 : 2'b11);
    chk("cfg_ras", RAS, ras_idle);
    step();
    chk("cfg_dsack_hold", DSACK, ack ? 2'b00 : 2'b11);
    AS20 = 1'b1; DS20 = 1'b1;
    step();
    chk("cfg_release", DSACK, 2'b11);
  endtask

  initial begin
    logic [23:0] ra;
    bit found;
`ifdef FASTRAM_AUTOCONFIG_EN
    model_cfg = 1'b0;
`else
    model_cfg = 1'b1;
`endif
    RESET = 1'b1;
    repeat (3) step();
    chk("reset_dsack", DSACK, 2'b11);
    chk("reset_ras", RAS, ras_idle);
    chk("reset_cas", CAS, 4'b1111);
    chk("reset_oe", RAMOE, 1'b1);
    chk("reset_mux", RAM_MUX, 1'b0);
    RESET = 1'b0;
    step();

`ifdef FASTRAM_AUTOCONFIG_EN
    wait_window(180);
    access(24'h200000, 1'b1, 2'b00, 0, 0, 0, 1'b0);
    cfg_write(24'hE80048, 8'h20, 1'b1);
    model_cfg = 1'b1; model_base_mb = 2;
`else
    cfg_write(24'hE80048, 8'h20, 1'b0);
`endif

    wait_window(180);
    access(24'h200000, 1'b1, 2'b00, 0, 0, 0, 1'b0);
    access(24'h200001, 1'b0, 2'b10, 1, 0, 0, 1'b0);
    access(24'h200003, 1'b0, 2'b00, 0, 1, 0, 1'b0);
    access(24'h200000, 1'b0, 2'b00, 3, 0, 0, 1'b0);
    wait_window(180);
    access(24'h1FFFFC, 1'b1, 2'b00, 0, 0, 0, 1'b0);
    access(24'h3FFFFC, 1'b1, 2'b00, 0, 0, 0, 1'b0);
    access(24'h400000, 1'b1, 2'b00, 0, 0, 0, 1'b0);
    access(24'h5FFFFC, 1'b0, 2'b11, 0, 0, 0, 1'b0);
    access(24'h600000, 1'b1, 2'b00, 0, 0, 0, 1'b0);

    wait_window(150);
    access(24'h300010, 1'b1, 2'b00, 0, 0, 0, 1'b1);
    access(24'h4A0002, 1'b0, 2'b01, 0, 0, PRECHARGE_CYC, 1'b0);

    for (int it = 0; it < 40; it++) begin
      ra = 24'h180000 + 24'($urandom_range(0, 24'h4FFFFF));
      wait_window(180);
      access(ra, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3), $urandom_range(0, 2), 0, 1'b0);
    end

    // Refresh tick coinciding with a hit: refresh runs first, hit served after.
    for (int i = 0; i < 400; i++) begin
      if (n_edges % REFRESH_DIV == 0) break;
      step();
    end
    A = 24'h200000; RW20 = 1'b1; SIZ = 2'b00; AS20 = 1'b0; DS20 = 1'b0;
    step();
    chk("ref_cas_cas", CAS, 4'b0000);
    chk("ref_cas_ras", RAS, ras_idle);
    chk("ref_cas_dsack", DSACK, 2'b11);
    step();
    chk("ref_ras1", RAS, '0);
    step();
    chk("ref_ras2", RAS, '0);
    step();
    chk("ref_pre_ras", RAS, ras_idle);
    chk("ref_pre_cas", CAS, 4'b1111);
    for (int i = 0; i < PRECHARGE_CYC; i++) begin
      step();
      chk("ref_pre_hold", RAS, ras_idle);
      chk("ref_pre_dsack", DSACK, 2'b11);
    end
    step();
    chk("post_ref_row", RAS, m_ras(24'h200000));
    step();
    chk("post_ref_col_dsack", DSACK, 2'b11);
    step();
    chk("post_ref_ack", DSACK, 2'b00);
    AS20 = 1'b1; DS20 = 1'b1;
    step(); step(); step();

    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (CAS == 4'b0000 && RAS == ras_idle) begin
        found = 1'b1;
        break;
      end
    end
    chk("idle_ref_seen", found, 1'b1);
    chk("idle_ref_phase", n_edges % REFRESH_DIV, 1);

    // Reset in the middle of an acknowledged cycle.
    wait_window(180);
    A = 24'h200000; RW20 = 1'b1; SIZ = 2'b00; AS20 = 1'b0; DS20 = 1'b0;
    step(); step(); step();
    chk("pre_reset_ack", DSACK, 2'b00);
    RESET = 1'b1;
    step();
    chk("rst_ack_ras", RAS, ras_idle);
    chk("rst_ack_dsack", DSACK, 2'b11);
    chk("rst_ack_cas", CAS, 4'b1111);
    chk("rst_ack_oe", RAMOE, 1'b1);
    RESET = 1'b0; AS20 = 1'b1; DS20 = 1'b1;
    step();
`ifdef FASTRAM_AUTOCONFIG_EN
    model_cfg = 1'b0;
`endif
    wait_window(180);
    access(24'h200000, 1'b1, 2'b00, 0, 0, 0, 1'b0);
`ifdef FASTRAM_AUTOCONFIG_EN
    cfg_write(24'hE8004C, 8'h00, 1'b1);
    cfg_write(24'hE80048, 8'h20, 1'b0);
    access(24'h200000, 1'b1, 2'b00, 0, 0, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
